// File: rtl/risc5_pipe_ctl_pkg.sv
// ---------------------------------------------------------------------------
// risc5_pipe_ctl_pkg
// Shared definitions for the 5-stage pipeline controller:
//   - memory-wait FSM state encodings (IDLE=0, WAIT=1)
//   - default pipeline payload widths, also used by the core top
//   - per-stage enable/flush bundle and the helper that derives it from the
//     freeze / load-use bubble / redirect decisions
// ---------------------------------------------------------------------------
package risc5_pipe_ctl_pkg;

    // Memory-wait FSM encodings, kept as plain constants so legacy code that
    // compares raw state bits keeps working.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Default payload widths for the core top.
    localparam int unsigned IFID_W_DEF  = 64;
    localparam int unsigned IDEX_W_DEF  = 160;
    localparam int unsigned EXMEM_W_DEF = 72;
    localparam int unsigned MEMWB_W_DEF = 72;

    // Enable / flush controls for the four pipeline registers.
    typedef struct packed {
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } stage_ctl_t;

    // frz     : memory wait, everything holds
    // bubble  : load-use, IF/ID holds and ID/EX becomes a bubble
    // flush_if: taken redirect, IF/ID is squashed
    // Callers qualify bubble and flush_if so that at most one is active.
    function automatic stage_ctl_t stage_ctl(input logic frz,
                                             input logic bubble,
                                             input logic flush_if);
        stage_ctl_t c;
        c.ifid_en    = ~frz & ~bubble;
        c.ifid_flush = flush_if;
        c.idex_en    = ~frz;
        c.idex_flush = bubble;
        c.exmem_en   = ~frz;
        c.memwb_en   = ~frz;
        return c;
    endfunction

endpackage

// File: rtl/risc5_pipe_ctl_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline register: payload plus valid bit.
//   clk, reset    : core clock, synchronous active-low reset
//   en            : advance (take valid_in, and d when valid_in is set)
//   flush         : squash to zero payload / invalid; wins over en
//   valid_in, d   : incoming valid and payload from the previous stage
//   q, valid_q    : registered payload and valid
// An invalid incoming stage leaves the held payload untouched, so only real
// instructions toggle the wide payload flops.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid_q
);

    logic [WIDTH-1:0] payload_d, payload_q;
    logic             valid_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps latches from being inferred.
        payload_d = payload_q;
        valid_d   = valid_q;
        if (flush) begin
            payload_d = '0;
            valid_d   = 1'b0;
        end else if (en) begin
            valid_d = valid_in;
            if (valid_in) begin
                payload_d = d;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops sample their _d values from the same pre-edge snapshot.
        if (!reset) begin
            // NOTE: the payload is reset as well because the registered
            // payloads are visible outputs that must read zero after reset.
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= valid_d;
        end
    end

    assign q = payload_q;

endmodule

// File: rtl/risc5_pipe_ctl.sv
// ---------------------------------------------------------------------------
// risc5_pipe_ctl
// Pipeline-register and stall/flush controller for the 5-stage RISC-V core.
// Holds the IF/ID, ID/EX, EX/MEM and MEM/WB payloads with valid bits, inserts
// load-use bubbles, squashes IF/ID on redirects, runs the data-memory req/ack
// handshake (freezing the pipe while waiting, with a timeout) and keeps
// cycle / retired / stall performance counters.
// Ports:
//   clk, reset                      core clock, synchronous active-low reset
//   valid_if, ifid_d..memwb_d       next payloads from the stage logic
//   load_use, redirect              hazard and branch/jump inputs from ID
//   mem_access, mem_ack             MEM-stage load/store and memory completion
//   ifid_q..memwb_q, valid_id..wb   registered payloads and valid bits
//   pc_en, freeze                   PC update enable, memory-wait freeze
//   mem_req, mem_err                memory request, sticky timeout flag
//   cnt_cycle/cnt_retired/cnt_stall performance counters (wrapping)
// ---------------------------------------------------------------------------
module risc5_pipe_ctl
    import risc5_pipe_ctl_pkg::*;
#(
    parameter int IFID_W      = IFID_W_DEF,
    parameter int IDEX_W      = IDEX_W_DEF,
    parameter int EXMEM_W     = EXMEM_W_DEF,
    parameter int MEMWB_W     = MEMWB_W_DEF,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_if,
    input  logic [IFID_W-1:0]  ifid_d,
    input  logic [IDEX_W-1:0]  idex_d,
    input  logic [EXMEM_W-1:0] exmem_d,
    input  logic [MEMWB_W-1:0] memwb_d,
    input  logic               load_use,
    input  logic               redirect,
    input  logic               mem_access,
    input  logic               mem_ack,
    output logic [IFID_W-1:0]  ifid_q,
    output logic [IDEX_W-1:0]  idex_q,
    output logic [EXMEM_W-1:0] exmem_q,
    output logic [MEMWB_W-1:0] memwb_q,
    output logic               valid_id,
    output logic               valid_ex,
    output logic               valid_mem,
    output logic               valid_wb,
    output logic               pc_en,
    output logic               freeze,
    output logic               mem_req,
    output logic               mem_err,
    output logic [CNT_W-1:0]   cnt_cycle,
    output logic [CNT_W-1:0]   cnt_retired,
    output logic [CNT_W-1:0]   cnt_stall
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

    logic [0:0]        state_d, state_q;
    logic [WCNT_W-1:0] wait_cnt_d, wait_cnt_q;
    logic              mem_err_d, mem_err_q;
    logic [CNT_W-1:0]  cnt_cycle_d, cnt_cycle_q;
    logic [CNT_W-1:0]  cnt_retired_d, cnt_retired_q;
    logic [CNT_W-1:0]  cnt_stall_d, cnt_stall_q;

    logic       timeout;
    logic       bubble;
    logic       flush_if;
    stage_ctl_t ctl;

    // ---------------- memory handshake and hazard decisions ----------------
    // In WAIT the request is held regardless of valid_mem: the frozen MEM
    // stage still owns the outstanding access.
    assign mem_req = (state_q == ST_WAIT) | (valid_mem & mem_access);

    // The last allowed wait cycle without an ack releases the pipe as if acked.
    assign timeout = (state_q == ST_WAIT) & ~mem_ack
                   & (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1));

    assign freeze   = mem_req & ~mem_ack & ~timeout;
    // Freeze dominates; a load-use bubble in turn drops a same-cycle redirect,
    // which ID re-presents once the hazard clears.
    assign bubble   = ~freeze & load_use & valid_id;
    assign flush_if = ~freeze & ~bubble & redirect;
    assign pc_en    = ~freeze & ~bubble;

    assign ctl = stage_ctl(freeze, bubble, flush_if);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | timeout;
        case (state_q)
            ST_IDLE: begin
                if (mem_req & ~mem_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ack | timeout) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ---------------- performance counters ----------------
    always_comb begin
        cnt_cycle_d   = cnt_cycle_q + CNT_W'(1);
        cnt_retired_d = cnt_retired_q;
        cnt_stall_d   = cnt_stall_q;
        if (valid_wb & ~freeze) begin
            cnt_retired_d = cnt_retired_q + CNT_W'(1);
        end
        if (freeze | (load_use & valid_id)) begin
            cnt_stall_d = cnt_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            cnt_cycle_q   <= '0;
            cnt_retired_q <= '0;
            cnt_stall_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            cnt_cycle_q   <= cnt_cycle_d;
            cnt_retired_q <= cnt_retired_d;
            cnt_stall_q   <= cnt_stall_d;
        end
    end

    assign mem_err     = mem_err_q;
    assign cnt_cycle   = cnt_cycle_q;
    assign cnt_retired = cnt_retired_q;
    assign cnt_stall   = cnt_stall_q;

    // ---------------- pipeline registers ----------------
    pipe_stage_reg #(.WIDTH(IFID_W)) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .en       (ctl.ifid_en),
        .flush    (ctl.ifid_flush),
        .valid_in (valid_if),
        .d        (ifid_d),
        .q        (ifid_q),
        .valid_q  (valid_id)
    );

    pipe_stage_reg #(.WIDTH(IDEX_W)) u_idex (
        .clk      (clk),
        .reset    (reset),
        .en       (ctl.idex_en),
        .flush    (ctl.idex_flush),
        .valid_in (valid_id),
        .d        (idex_d),
        .q        (idex_q),
        .valid_q  (valid_ex)
    );

    pipe_stage_reg #(.WIDTH(EXMEM_W)) u_exmem (
        .clk      (clk),
        .reset    (reset),
        .en       (ctl.exmem_en),
        .flush    (1'b0),
        .valid_in (valid_ex),
        .d        (exmem_d),
        .q        (exmem_q),
        .valid_q  (valid_mem)
    );

    pipe_stage_reg #(.WIDTH(MEMWB_W)) u_memwb (
        .clk      (clk),
        .reset    (reset),
        .en       (ctl.memwb_en),
        .flush    (1'b0),
        .valid_in (valid_mem),
        .d        (memwb_d),
        .q        (memwb_q),
        .valid_q  (valid_wb)
    );

endmodule

// File: tb/tb_risc5_pipe_ctl.sv
// ---------------------------------------------------------------------------
// tb_risc5_pipe_ctl
// Scoreboarded bench for risc5_pipe_ctl. The driver applies inputs each cycle,
// asks a behavioural model what the outputs should be and queues that
// expectation; an independent monitor pops and compares. Directed scenarios
// (reset mid-wait, load-use, redirect, load-use+redirect, memory wait,
// timeout) are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_risc5_pipe_ctl;

    localparam int IFID_W      = 64;
    localparam int IDEX_W      = 160;
    localparam int EXMEM_W     = 72;
    localparam int MEMWB_W     = 72;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, valid_if, load_use, redirect, mem_access, mem_ack;
    logic [IFID_W-1:0]  ifid_d;
    logic [IDEX_W-1:0]  idex_d;
    logic [EXMEM_W-1:0] exmem_d;
    logic [MEMWB_W-1:0] memwb_d;
    logic [IFID_W-1:0]  ifid_q;
    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_q;
    logic [MEMWB_W-1:0] memwb_q;
    logic               valid_id, valid_ex, valid_mem, valid_wb;
    logic               pc_en, freeze, mem_req, mem_err;
    logic [CNT_W-1:0]   cnt_cycle, cnt_retired, cnt_stall;

    risc5_pipe_ctl #(
        .IFID_W(IFID_W), .IDEX_W(IDEX_W), .EXMEM_W(EXMEM_W), .MEMWB_W(MEMWB_W),
        .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_if(valid_if),
        .ifid_d(ifid_d), .idex_d(idex_d), .exmem_d(exmem_d), .memwb_d(memwb_d),
        .load_use(load_use), .redirect(redirect),
        .mem_access(mem_access), .mem_ack(mem_ack),
        .ifid_q(ifid_q), .idex_q(idex_q), .exmem_q(exmem_q), .memwb_q(memwb_q),
        .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .pc_en(pc_en), .freeze(freeze), .mem_req(mem_req), .mem_err(mem_err),
        .cnt_cycle(cnt_cycle), .cnt_retired(cnt_retired), .cnt_stall(cnt_stall)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [IDEX_W-1:0] act,
                         input logic [IDEX_W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The pipe is four slots; a memory access that is not acked freezes the
    // whole pipe until it is acked or has already been frozen MEM_TIMEOUT-1
    // cycles, in which case it is released with a sticky error.
    logic [IFID_W-1:0]  m_ifid;
    logic [IDEX_W-1:0]  m_idex;
    logic [EXMEM_W-1:0] m_exmem;
    logic [MEMWB_W-1:0] m_memwb;
    logic               m_vid, m_vex, m_vmem, m_vwb, m_err;
    logic [CNT_W-1:0]   m_cyc, m_ret, m_stl;
    int                 m_frozen_for;   // cycles the current access has been frozen
    logic               m_req, m_tout, m_frz, m_bub, m_pc;

    function automatic void model_reset();
        m_ifid = '0; m_idex = '0; m_exmem = '0; m_memwb = '0;
        m_vid = 0; m_vex = 0; m_vmem = 0; m_vwb = 0; m_err = 0;
        m_cyc = '0; m_ret = '0; m_stl = '0;
        m_frozen_for = 0;
    endfunction

    function automatic void model_comb();
        m_req  = (m_frozen_for > 0) || (m_vmem && mem_access);
        m_tout = (m_frozen_for == MEM_TIMEOUT - 1) && !mem_ack;
        m_frz  = m_req && !mem_ack && !m_tout;
        m_bub  = !m_frz && load_use && m_vid;
        m_pc   = !m_frz && !m_bub;
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        m_cyc = m_cyc + 1;
        if (m_vwb && !m_frz) m_ret = m_ret + 1;
        if (m_frz || (load_use && m_vid)) m_stl = m_stl + 1;
        if (m_tout) m_err = 1;
        m_frozen_for = m_frz ? m_frozen_for + 1 : 0;
        if (!m_frz) begin
            if (m_vmem) m_memwb = memwb_d;
            m_vwb = m_vmem;
            if (m_vex) m_exmem = exmem_d;
            m_vmem = m_vex;
            if (m_bub) begin
                m_idex = '0;
                m_vex  = 0;
            end else begin
                if (m_vid) m_idex = idex_d;
                m_vex = m_vid;
            end
            if (!m_bub) begin
                if (redirect) begin
                    m_ifid = '0;
                    m_vid  = 0;
                end else begin
                    if (valid_if) m_ifid = ifid_d;
                    m_vid = valid_if;
                end
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [IFID_W-1:0]  ifid;
        logic [IDEX_W-1:0]  idex;
        logic [EXMEM_W-1:0] exmem;
        logic [MEMWB_W-1:0] memwb;
        logic               vid, vex, vmem, vwb;
        logic               pc_en, freeze, mem_req, mem_err;
        logic [CNT_W-1:0]   cyc, ret, stl;
    } exp_t;

    exp_t exp_q[$];

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ifid_q",      IDEX_W'(ifid_q),      IDEX_W'(e.ifid));
                check("idex_q",      idex_q,               e.idex);
                check("exmem_q",     IDEX_W'(exmem_q),     IDEX_W'(e.exmem));
                check("memwb_q",     IDEX_W'(memwb_q),     IDEX_W'(e.memwb));
                check("valid_id",    IDEX_W'(valid_id),    IDEX_W'(e.vid));
                check("valid_ex",    IDEX_W'(valid_ex),    IDEX_W'(e.vex));
                check("valid_mem",   IDEX_W'(valid_mem),   IDEX_W'(e.vmem));
                check("valid_wb",    IDEX_W'(valid_wb),    IDEX_W'(e.vwb));
                check("pc_en",       IDEX_W'(pc_en),       IDEX_W'(e.pc_en));
                check("freeze",      IDEX_W'(freeze),      IDEX_W'(e.freeze));
                check("mem_req",     IDEX_W'(mem_req),     IDEX_W'(e.mem_req));
                check("mem_err",     IDEX_W'(mem_err),     IDEX_W'(e.mem_err));
                check("cnt_cycle",   IDEX_W'(cnt_cycle),   IDEX_W'(e.cyc));
                check("cnt_retired", IDEX_W'(cnt_retired), IDEX_W'(e.ret));
                check("cnt_stall",   IDEX_W'(cnt_stall),   IDEX_W'(e.stl));
            end
        end
    end

    // ---------------- driver ----------------
    logic              fix_a5 = 1'b0;
    logic              obs_freeze, obs_pc_en, obs_mem_req, obs_err, obs_vid, obs_vex, obs_vwb;
    logic [IFID_W-1:0] obs_ifid;
    logic [CNT_W-1:0]  obs_stl, obs_cyc;

    task automatic step(input logic rst_v, input logic v_if, input logic lu,
                        input logic rd, input logic ma, input logic ack);
        logic [159:0] r;
        exp_t e;
        @(negedge clk);
        reset      = rst_v;
        valid_if   = v_if;
        load_use   = lu;
        redirect   = rd;
        mem_access = ma;
        mem_ack    = ack;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ifid_d  = fix_a5 ? IFID_W'(64'hA5) : r[63:0];
        idex_d  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        exmem_d = r[71:0];
        memwb_d = r[159:88];
        #1;
        model_comb();
        e.ifid = m_ifid; e.idex = m_idex; e.exmem = m_exmem; e.memwb = m_memwb;
        e.vid = m_vid; e.vex = m_vex; e.vmem = m_vmem; e.vwb = m_vwb;
        e.pc_en = m_pc; e.freeze = m_frz; e.mem_req = m_req; e.mem_err = m_err;
        e.cyc = m_cyc; e.ret = m_ret; e.stl = m_stl;
        exp_q.push_back(e);
        obs_freeze = freeze;  obs_pc_en = pc_en;   obs_mem_req = mem_req;
        obs_err    = mem_err; obs_vid   = valid_id; obs_vex = valid_ex;
        obs_vwb    = valid_wb; obs_ifid = ifid_q;  obs_stl = cnt_stall; obs_cyc = cnt_cycle;
        @(posedge clk);
        model_edge();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [IFID_W-1:0] ifid_before;
        logic [CNT_W-1:0]  stall_before;
        int                frz_cnt;

        reset = 0; valid_if = 0; load_use = 0; redirect = 0;
        mem_access = 0; mem_ack = 0;
        ifid_d = '0; idex_d = '0; exmem_d = '0; memwb_d = '0;
        model_reset();

        // Power-up reset.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_ifid",  IDEX_W'(obs_ifid), '0);
        check("rst_cycle", IDEX_W'(obs_cyc),  '0);
        check("rst_err",   IDEX_W'(obs_err),  '0);
        fill(5);

        // Load-use: PC held, IF/ID held, bubble into EX, one stall counted.
        step(1, 1, 1, 0, 0, 0);
        ifid_before  = obs_ifid;
        stall_before = obs_stl;
        check("lu_pc_en", IDEX_W'(obs_pc_en), '0);
        step(1, 1, 0, 0, 0, 0);
        check("lu_ifid_held", IDEX_W'(obs_ifid), IDEX_W'(ifid_before));
        check("lu_valid_ex",  IDEX_W'(obs_vex),  '0);
        check("lu_stall",     IDEX_W'(obs_stl),  IDEX_W'(stall_before + 1));

        // Redirect with ifid_d = A5: IF/ID squashed, PC still advances.
        fix_a5 = 1'b1;
        step(1, 1, 0, 1, 0, 0);
        fix_a5 = 1'b0;
        check("rd_pc_en", IDEX_W'(obs_pc_en), IDEX_W'(1));
        step(1, 1, 0, 0, 0, 0);
        check("rd_ifid",  IDEX_W'(obs_ifid), '0);
        check("rd_vid",   IDEX_W'(obs_vid),  '0);

        // Load-use and redirect together: bubble only, IF/ID holds.
        step(1, 1, 1, 1, 0, 0);
        ifid_before = obs_ifid;
        step(1, 1, 0, 0, 0, 0);
        check("lurd_ifid", IDEX_W'(obs_ifid), IDEX_W'(ifid_before));
        check("lurd_vid",  IDEX_W'(obs_vid),  IDEX_W'(1));

        // Memory wait, ack on the fourth cycle.
        fill(4);
        frz_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 1, 0);
            if (i == 0) stall_before = obs_stl;
            if (obs_freeze) frz_cnt++;
        end
        check("wait_frz_cycles", IDEX_W'(frz_cnt), IDEX_W'(3));
        step(1, 1, 0, 0, 1, 1);
        check("wait_release", IDEX_W'(obs_freeze), '0);
        step(1, 1, 0, 0, 0, 0);
        check("wait_stall", IDEX_W'(obs_stl), IDEX_W'(stall_before + 3));

        // Timeout: never acked, released after 3 frozen cycles, error sticks.
        fill(4);
        frz_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 1, 0);
            if (obs_freeze) frz_cnt++;
        end
        check("tout_frz_cycles", IDEX_W'(frz_cnt), IDEX_W'(3));
        step(1, 1, 0, 0, 1, 0);
        check("tout_err",      IDEX_W'(obs_err),    IDEX_W'(1));
        check("tout_reenter",  IDEX_W'(obs_freeze), IDEX_W'(1));
        step(1, 1, 0, 0, 1, 1);
        fill(3);
        step(1, 1, 0, 0, 0, 0);
        check("tout_err_sticky", IDEX_W'(obs_err), IDEX_W'(1));

        // Reset in the middle of a wait.
        fill(3);
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        check("rstw_mem_req", IDEX_W'(obs_mem_req), '0);
        check("rstw_err",     IDEX_W'(obs_err),     '0);
        check("rstw_cycle",   IDEX_W'(obs_cyc),     '0);
        check("rstw_vwb",     IDEX_W'(obs_vwb),     '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) >= 2),
                 ($urandom_range(99) < 80),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 35),
                 ($urandom_range(99) < 45));
        end

        @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
